sevenseg_scan_decoder: RTL and testbench
========================================

# sevenseg_scan_decoder

Receive-side counterpart of the four-digit multiplexed seven-segment driver. Samples the time-multiplexed segment bus and active-low anode strobes, and waits until each pattern is stable. It then decodes each accepted pattern back to a BCD digit and assembles the four digits into a frame, publishing a one-cycle `frame_valid` per complete frame. Used as a display monitor and loopback checker in the same clock domain as the driver.

## Interface
- `STABLE_CYCLES`, 16: consecutive unchanged sampling edges required before a pattern is accepted; legal range 2..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `ssego`  input  7  segment bus, active-low (0 = lit); bit0 = a … bit6 = g.
- `an0`  input  4  anode strobes, active-low; `an0[i]` = 0 selects digit i.
- `frame_digits`  output  16  last complete frame; digit i in bits [4i+3:4i].
- `frame_err`  output  4  per-digit error flags for `frame_digits`.
- `frame_valid`  output  1  one-cycle pulse when `frame_digits`/`frame_err` update.
- `anode_err`  output  1  one-cycle pulse on an accepted sample with more than one anode active.

## Operation
- **Input register.** `sample_r <= {an0, ssego}` every edge; reset value `{4'hF, 7'h7F}`.
- **Stability counter.** `cnt` is sized `$clog2(STABLE_CYCLES+1)` and resets to 0.
  - If the new sample differs from `sample_r`: `cnt <= 0`.
  - Else if `cnt != STABLE_CYCLES`: `cnt <= cnt + 1`.
  - Saturates at `STABLE_CYCLES`.
- **Accept.** `accept = (cnt == STABLE_CYCLES-1) && (new sample == sample_r)`. This fires exactly once per stable window; a held pattern is never re-accepted until it changes.
- **Anode classification on accept**, using `an = sample_r[10:7]`:
  - `4'hF`: blanking interval; ignored.
  - Exactly one zero bit: digit index = position of that zero.
  - Two or more zeros: `anode_err` pulses; no capture.
- **Segment decode** (active-low):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 7F → blank, value 4'hF, err 0.
  - Any other pattern → value 4'hE, err 1.
- **Capture buffer.** `cap_digits[15:0]`, `cap_err[3:0]`, and `seen[3:0]`. On a valid accept, write digit i and its err bit and set `seen[i]`. A repeated digit before frame completion overwrites the value; `seen` is unchanged.
- **Frame completion.** When `seen | (1<<i) == 4'hF` on a valid accept, the same edge performs all of:
  - `frame_digits <= cap_digits` with digit i merged.
  - `frame_err <= cap_err` with bit i merged.
  - `frame_valid <= 1`.
  - `seen <= 0`.
- **Output buffering.** `frame_digits` and `frame_err` hold between completions; a partial frame never reaches the outputs.
- **Reset values.**
  - `frame_digits = 16'hFFFF`, `frame_err = 0`, `frame_valid = 0`, `anode_err = 0`.
  - `cnt = 0`, `seen = 0`, `cap_digits = 16'hFFFF`, `cap_err = 0`.
- **Reset mid-frame.** The partial frame is discarded; the next frame starts from an empty `seen`.

## Timing
- Let edge k be the first edge that samples a new `{an0, ssego}` value, held constant thereafter.
  - After edge k: `cnt = 0`.
  - Accept is evaluated in the cycle before edge k+STABLE_CYCLES.
  - Capture, and any frame publish or `anode_err` pulse, registers at edge k+STABLE_CYCLES.
- Minimum hold time for acceptance is STABLE_CYCLES+1 edges. A pattern that changes earlier (segment glitch, anode transition) is never captured.
- `frame_valid` and `anode_err` are high for exactly one cycle and low in the following cycle, unless a new qualifying accept occurs; back-to-back accepts are impossible because each needs a fresh stable window.
- Reset dominates any same-edge accept.
- No backpressure: the consumer must sample `frame_digits` no later than the cycle `frame_valid` is high if it needs that frame, because the next completion overwrites it.

## Test plan
- **Basic frame.** Scan digits 0..3 with patterns 40, 79, 24, 30, each held 20 cycles (STABLE_CYCLES=16) → `frame_valid` one cycle, exactly 16 edges after digit 3's first sampling edge; `frame_digits = 16'h3210`, `frame_err = 0`.
- **Glitch rejection.** Hold digit 1 with 79, insert a 5-cycle pulse of 00, then hold 79 for 20 cycles → only one digit-1 accept, value 1. The 00 value is never captured.
- **Invalid pattern and blank.** Digit 2 = 7'h7E, digit 3 = 7'h7F; others valid → digit 2 = E with `frame_err[2] = 1`, digit 3 = F with `frame_err[3] = 0`.
- **Anode fault.** Hold `an0 = 4'b1100` for 20 cycles → `anode_err` pulses once; `seen` unchanged; no `frame_valid`.
- **Overwrite and blanking.** Scan digit 0 twice (values 5 then 8) with `an0 = 4'hF` gaps, then digits 1..3 → frame shows 8 at digit 0; exactly one `frame_valid`.
- **Reset mid-frame.** Capture digits 0 and 1, pulse `rst_n` low for 1 cycle → outputs return to FFFF/0/0. Then capture only digits 2 and 3 → no `frame_valid` until digits 0 and 1 are recaptured.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// Watches a time-multiplexed, active-low seven-segment bus with active-low
// anode strobes, waits for each pattern to settle, decodes it back to a BCD
// digit and publishes complete four-digit frames with per-digit error flags.

module sevenseg_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  ssego,
  input  logic [3:0]  an0,
  output logic [15:0] frame_digits,
  output logic [3:0]  frame_err,
  output logic        frame_valid,
  output logic        anode_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  logic [10:0]   sample_r;
  logic [10:0]   sample_new;
  logic          same;
  logic [CW-1:0] cnt;
  logic          accept;

  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic [2:0]    zero_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    digit_mask;
  logic [3:0]    seg_val;
  logic          seg_err;

  logic [15:0]   cap_digits;
  logic [3:0]    cap_err;
  logic [3:0]    seen;
  logic [15:0]   merged_digits;
  logic [3:0]    merged_err;

  assign sample_new = {an0, ssego};
  assign same       = (sample_new == sample_r);
  assign accept     = same && (cnt == CNT_ACC);
  assign an_s       = sample_r[10:7];
  assign seg_s      = sample_r[6:0];
  assign digit_mask = 4'b0001 << digit_idx;

  // Register the bus and count how long the current pattern has been unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_r <= 11'h7FF;
      cnt      <= '0;
    end else begin
      sample_r <= sample_new;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Count active anodes and locate the selected digit (meaningful only when exactly one is active).
  always_comb begin
    zero_cnt  = '0;
    digit_idx = '0;
    for (int j = 0; j < 4; j++) begin
      if (!an_s[j]) begin
        zero_cnt  = zero_cnt + 3'd1;
        digit_idx = 2'(j);
      end
    end
  end

  // Map an active-low segment pattern back to a BCD value; blank is F, anything unknown is E with error.
  always_comb begin
    seg_val = 4'hE;
    seg_err = 1'b1;
    case (seg_s)
      7'h40: begin seg_val = 4'h0; seg_err = 1'b0; end
      7'h79: begin seg_val = 4'h1; seg_err = 1'b0; end
      7'h24: begin seg_val = 4'h2; seg_err = 1'b0; end
      7'h30: begin seg_val = 4'h3; seg_err = 1'b0; end
      7'h19: begin seg_val = 4'h4; seg_err = 1'b0; end
      7'h12: begin seg_val = 4'h5; seg_err = 1'b0; end
      7'h02: begin seg_val = 4'h6; seg_err = 1'b0; end
      7'h78: begin seg_val = 4'h7; seg_err = 1'b0; end
      7'h00: begin seg_val = 4'h8; seg_err = 1'b0; end
      7'h10: begin seg_val = 4'h9; seg_err = 1'b0; end
      7'h7F: begin seg_val = 4'hF; seg_err = 1'b0; end
      default: begin seg_val = 4'hE; seg_err = 1'b1; end
    endcase
  end

  // Capture buffer with the currently decoded digit folded in, so completion can publish in one edge.
  always_comb begin
    merged_digits = cap_digits;
    merged_err    = cap_err;
    for (int j = 0; j < 4; j++) begin
      if (digit_idx == 2'(j)) begin
        merged_digits[4*j +: 4] = seg_val;
        merged_err[j]           = seg_err;
      end
    end
  end

  // On each accepted sample, capture the digit, flag anode faults and publish finished frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_digits   <= 16'hFFFF;
      cap_err      <= 4'h0;
      seen         <= 4'h0;
      frame_digits <= 16'hFFFF;
      frame_err    <= 4'h0;
      frame_valid  <= 1'b0;
      anode_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      anode_err   <= 1'b0;
      if (accept && (an_s != 4'hF)) begin
        if (zero_cnt == 3'd1) begin
          cap_digits <= merged_digits;
          cap_err    <= merged_err;
          if ((seen | digit_mask) == 4'hF) begin
            frame_digits <= merged_digits;
            frame_err    <= merged_err;
            frame_valid  <= 1'b1;
            seen         <= 4'h0;
          end else begin
            seen <= seen | digit_mask;
          end
        end else begin
          anode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder
// Directed scan sequences against sevenseg_scan_decoder with hand-computed
// expected frames, pulse counts and pulse timing.

module tb_sevenseg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  ssego;
  logic [3:0]  an0;
  logic [15:0] frame_digits;
  logic [3:0]  frame_err;
  logic        frame_valid;
  logic        anode_err;

  int testsRun = 0;
  int testsFailed = 0;
  int fvCount = 0;
  int aeCount = 0;
  int fvAt = -1;
  int aeAt = -1;

  sevenseg_scan_decoder #(.STABLE_CYCLES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ssego        (ssego),
    .an0          (an0),
    .frame_digits (frame_digits),
    .frame_err    (frame_err),
    .frame_valid  (frame_valid),
    .anode_err    (anode_err)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one pattern from a falling edge and hold it for n cycles, recording output pulses.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n);
    an0   = an;
    ssego = seg;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        fvCount++;
        fvAt = i;
      end
      if (anode_err) begin
        aeCount++;
        aeAt = i;
      end
    end
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    fvCount = 0;
    aeCount = 0;
    fvAt    = -1;
    aeAt    = -1;
  endtask

  // Directed test sequence.
  initial begin
    rst_n = 1'b0;
    an0   = 4'hF;
    ssego = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("reset_digits", 32'(frame_digits), 32'hFFFF);
    checkOutput("reset_err",    32'(frame_err),    32'h0);
    checkOutput("reset_valid",  32'(frame_valid),  32'h0);
    checkOutput("reset_aerr",   32'(anode_err),    32'h0);

    // Basic frame 0,1,2,3.
    clearCounts();
    applyStimulus(4'b1110, 7'h40, 20);
    applyStimulus(4'b1101, 7'h79, 20);
    applyStimulus(4'b1011, 7'h24, 20);
    checkOutput("basic_no_early_valid", 32'(fvCount), 32'd0);
    applyStimulus(4'b0111, 7'h30, 20);
    checkOutput("basic_valid_count", 32'(fvCount), 32'd1);
    checkOutput("basic_valid_time",  32'(fvAt),    32'd16);
    checkOutput("basic_digits", 32'(frame_digits), 32'h3210);
    checkOutput("basic_err",    32'(frame_err),    32'h0);

    // Glitch rejection on digit 1.
    clearCounts();
    applyStimulus(4'b1110, 7'h40, 20);
    applyStimulus(4'b1101, 7'h79, 6);
    applyStimulus(4'b1101, 7'h00, 5);
    applyStimulus(4'b1101, 7'h79, 20);
    applyStimulus(4'b1011, 7'h24, 20);
    applyStimulus(4'b0111, 7'h30, 20);
    checkOutput("glitch_valid_count", 32'(fvCount), 32'd1);
    checkOutput("glitch_digits", 32'(frame_digits), 32'h3210);

    // Invalid pattern on digit 2, blank on digit 3.
    clearCounts();
    applyStimulus(4'b1110, 7'h19, 20);
    applyStimulus(4'b1101, 7'h12, 20);
    applyStimulus(4'b1011, 7'h7E, 20);
    applyStimulus(4'b0111, 7'h7F, 20);
    checkOutput("inval_valid_count", 32'(fvCount), 32'd1);
    checkOutput("inval_digits", 32'(frame_digits), 32'hFE54);
    checkOutput("inval_err",    32'(frame_err),    32'h4);

    // Anode fault between digit 0 and the rest of the frame.
    clearCounts();
    applyStimulus(4'b1110, 7'h02, 20);
    applyStimulus(4'b1100, 7'h78, 20);
    checkOutput("anode_err_count", 32'(aeCount), 32'd1);
    checkOutput("anode_err_time",  32'(aeAt),    32'd16);
    checkOutput("anode_no_valid",  32'(fvCount), 32'd0);
    applyStimulus(4'b1101, 7'h78, 20);
    applyStimulus(4'b1011, 7'h00, 20);
    checkOutput("anode_seen_kept", 32'(fvCount), 32'd0);
    applyStimulus(4'b0111, 7'h10, 20);
    checkOutput("anode_frame_valid", 32'(fvCount), 32'd1);
    checkOutput("anode_digits", 32'(frame_digits), 32'h9876);
    checkOutput("anode_err_total", 32'(aeCount), 32'd1);

    // Overwrite digit 0 with blanking gaps.
    clearCounts();
    applyStimulus(4'b1110, 7'h12, 20);
    applyStimulus(4'hF,    7'h7F, 20);
    applyStimulus(4'b1110, 7'h00, 20);
    applyStimulus(4'hF,    7'h7F, 20);
    applyStimulus(4'b1101, 7'h79, 20);
    applyStimulus(4'b1011, 7'h24, 20);
    applyStimulus(4'b0111, 7'h30, 20);
    checkOutput("ovr_valid_count", 32'(fvCount), 32'd1);
    checkOutput("ovr_digits", 32'(frame_digits), 32'h3218);
    checkOutput("ovr_err",    32'(frame_err),    32'h0);

    // Reset mid-frame discards partial capture.
    clearCounts();
    applyStimulus(4'b1110, 7'h40, 20);
    applyStimulus(4'b1101, 7'h79, 20);
    rst_n = 1'b0;
    an0   = 4'hF;
    ssego = 7'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_digits", 32'(frame_digits), 32'hFFFF);
    checkOutput("rst_err",    32'(frame_err),    32'h0);
    checkOutput("rst_valid",  32'(frame_valid),  32'h0);
    applyStimulus(4'b1011, 7'h24, 20);
    applyStimulus(4'b0111, 7'h30, 20);
    checkOutput("rst_no_valid", 32'(fvCount), 32'd0);
    checkOutput("rst_outputs_held", 32'(frame_digits), 32'hFFFF);
    applyStimulus(4'b1110, 7'h40, 20);
    applyStimulus(4'b1101, 7'h79, 20);
    checkOutput("rst_valid_count", 32'(fvCount), 32'd1);
    checkOutput("rst_frame_digits", 32'(frame_digits), 32'h3210);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
